bist_multi_comparator: RTL

//  Multi-channel BIST result comparator; successor to the single-word sticky comparator.

---
 rtl/bist_multi_comparator.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/bist_multi_comparator.sv
// bist_multi_comparator: multi-lane BIST result compare with sticky per-channel flags and a saturating fail count.
// Define BIST_CMP_FAIL_LOG_EN to add first-failing-beat capture (first_addr_o/first_ch_o/first_act_o/first_exp_o).
//
// state | meaning
// IDLE  | no session since reset
// RUN   | accepting beats; a captured last beat closes acceptance
// FLUSH | last beat draining through the compare pipeline
// DONE  | results final, held until start_i
module bist_multi_comparator #(
  parameter int DATA_W      = 32,
  parameter int NCH         = 4,
  parameter int ADDR_W      = 10,
  parameter int CNT_W       = 16,
  parameter int IGNORE_ZERO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  valid_i,
  input  logic                  last_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [NCH*DATA_W-1:0] actual_i,
  input  logic [NCH*DATA_W-1:0] expected_i,
  input  logic [NCH-1:0]        ch_mask_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  error_o,
  output logic [NCH-1:0]        ch_error_o,
  output logic [CNT_W-1:0]      fail_cnt_o
`ifdef BIST_CMP_FAIL_LOG_EN
  ,
  output logic [ADDR_W-1:0]     first_addr_o,
  output logic [NCH-1:0]        first_ch_o,
  output logic [DATA_W-1:0]     first_act_o,
  output logic [DATA_W-1:0]     first_exp_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_s0_vld, r_s0_last;
  logic [NCH*DATA_W-1:0] r_s0_act, r_s0_exp;
  logic [NCH-1:0]        r_s0_mask;
  logic                  r_s1_vld;
  logic [NCH-1:0]        r_s1_mis;
  logic                  r_error;
  logic [NCH-1:0]        r_ch_error;
  logic [CNT_W-1:0]      r_fail_cnt;
  logic                  w_accept, w_last_seen;
  logic [NCH-1:0]        w_mis;

  // Once the last beat sits in stage 0 nothing more is taken, even though the FSM is still in RUN.
  assign w_last_seen = r_s0_vld & r_s0_last;
  assign w_accept    = (r_state == S_RUN) & valid_i & ~start_i & ~w_last_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start_i) begin
      w_state_nxt = S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (w_last_seen) w_state_nxt = S_FLUSH;
        S_FLUSH: w_state_nxt = S_DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0_vld  <= 1'b0;
      r_s0_last <= 1'b0;
      r_s0_act  <= '0;
      r_s0_exp  <= '0;
      r_s0_mask <= '0;
    end else begin
      r_s0_vld <= w_accept;
      if (w_accept) begin
        r_s0_last <= last_i;
        r_s0_act  <= actual_i;
        r_s0_exp  <= expected_i;
        r_s0_mask <= ch_mask_i;
      end
    end
  end

  // Case inequality so X/Z on the observed data counts as a mismatch.
  always_comb begin
    w_mis = '0;
    for (int c = 0; c < NCH; c++) begin
      if (!r_s0_mask[c] &&
          (r_s0_act[c*DATA_W +: DATA_W] !== r_s0_exp[c*DATA_W +: DATA_W]) &&
          (IGNORE_ZERO == 0 || r_s0_act[c*DATA_W +: DATA_W] !== '0))
        w_mis[c] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_mis <= '0;
    end else begin
      r_s1_vld <= r_s0_vld & ~start_i;
      if (r_s0_vld) r_s1_mis <= w_mis;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_error    <= 1'b0;
      r_ch_error <= '0;
      r_fail_cnt <= '0;
    end else if (start_i) begin
      r_error    <= 1'b0;
      r_ch_error <= '0;
      r_fail_cnt <= '0;
    end else if (r_s1_vld && (|r_s1_mis)) begin
      r_error    <= 1'b1;
      r_ch_error <= r_ch_error | r_s1_mis;
      if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 1'b1;
    end
  end

  assign busy_o     = (r_state == S_RUN) | (r_state == S_FLUSH);
  assign done_o     = (r_state == S_DONE);
  assign pass_o     = done_o & ~r_error;
  assign error_o    = r_error;
  assign ch_error_o = r_ch_error;
  assign fail_cnt_o = r_fail_cnt;

`ifdef BIST_CMP_FAIL_LOG_EN
  logic [ADDR_W-1:0] r_s0_addr, r_s1_addr, r_first_addr;
  logic [NCH-1:0]    r_s1_ch, r_first_ch, w_first_ch;
  logic [DATA_W-1:0] r_s1_act, r_s1_exp, r_first_act, r_first_exp;
  logic [DATA_W-1:0] w_first_act, w_first_exp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_s0_addr <= '0;
    else if (w_accept) r_s0_addr <= addr_i;
  end

  // Descending scan so the lowest failing channel wins.
  always_comb begin
    w_first_ch  = '0;
    w_first_act = '0;
    w_first_exp = '0;
    for (int c = NCH-1; c >= 0; c--) begin
      if (w_mis[c]) begin
        w_first_ch    = '0;
        w_first_ch[c] = 1'b1;
        w_first_act   = r_s0_act[c*DATA_W +: DATA_W];
        w_first_exp   = r_s0_exp[c*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_addr <= '0;
      r_s1_ch   <= '0;
      r_s1_act  <= '0;
      r_s1_exp  <= '0;
    end else if (r_s0_vld) begin
      r_s1_addr <= r_s0_addr;
      r_s1_ch   <= w_first_ch;
      r_s1_act  <= w_first_act;
      r_s1_exp  <= w_first_exp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first_addr <= '0;
      r_first_ch   <= '0;
      r_first_act  <= '0;
      r_first_exp  <= '0;
    end else if (start_i) begin
      r_first_addr <= '0;
      r_first_ch   <= '0;
      r_first_act  <= '0;
      r_first_exp  <= '0;
    end else if (r_s1_vld && (|r_s1_mis) && !r_error) begin
      r_first_addr <= r_s1_addr;
      r_first_ch   <= r_s1_ch;
      r_first_act  <= r_s1_act;
      r_first_exp  <= r_s1_exp;
    end
  end

  assign first_addr_o = r_first_addr;
  assign first_ch_o   = r_first_ch;
  assign first_act_o  = r_first_act;
  assign first_exp_o  = r_first_exp;
`else
  logic w_unused_addr;
  assign w_unused_addr = ^addr_i;
`endif

endmodule
